transmisor_uart: RTL and testbench

UART 8N1 transmitter, the sending end of the serial link whose receiving end feeds the seven-segment display board. It accepts a byte on a single-cycle valid strobe, serializes it LSB-first with one start bit and one stop bit at a fixed bit period of `CLKS_PER_BIT` clocks, and reports busy and completion status. It sits between byte-producing logic (switches, a test-pattern counter, a host FSM) and the physical `o_Tx_Serial` pin.

---
 rtl/transmisor_uart.sv | 166 ++++++++++++++++
 tb/tb_transmisor_uart.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/transmisor_uart.sv
// ---------------------------------------------------------------------------
// transmisor_uart
//   UART 8N1 transmitter. Accepts a byte on a single-cycle valid strobe while
//   idle and sends it LSB-first: one start bit (0), eight data bits, one stop
//   bit (1). Each bit lasts CLKS_PER_BIT clocks. The line idles high.
//
// Parameters
//   CLKS_PER_BIT : clocks per serial bit (default 87 = 10 MHz / 115200), >= 2
//
// Ports
//   i_Clock     : clock, rising-edge active
//   i_Reset     : asynchronous, active-high reset
//   i_Tx_DV     : byte-valid strobe, only sampled in IDLE
//   i_Tx_Byte   : byte to send, captured on the accepting edge
//   o_Tx_Serial : serial line output, idles high
//   o_Tx_Active : high while a frame is on the line
//   o_Tx_Done   : one-cycle pulse after the stop bit completes
// ---------------------------------------------------------------------------
module transmisor_uart #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [CNT_W-1:0] w_clk_cnt_next;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic [7:0]       r_byte;
  logic [7:0]       w_byte_next;
  logic             r_serial;
  logic             w_serial_next;
  logic             r_active;
  logic             w_active_next;
  logic             r_done;
  logic             w_done_next;
  logic             w_bit_end;
  logic [2:0]       w_bit_idx_inc;

  assign w_bit_end     = (r_clk_cnt == CNT_LAST);
  assign w_bit_idx_inc = r_bit_idx + 3'd1;

  // All outputs are registered so the line changes right after each edge.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_byte    <= '0;
      r_serial  <= 1'b1;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_byte    <= w_byte_next;
      r_serial  <= w_serial_next;
      r_active  <= w_active_next;
      r_done    <= w_done_next;
    end
  end

  // Next-state logic: the value written here is what the line shows for the
  // cycle after the edge, so each transition already drives the next bit.
  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = r_clk_cnt;
    w_bit_idx_next = r_bit_idx;
    w_byte_next    = r_byte;
    w_serial_next  = r_serial;
    w_active_next  = r_active;
    w_done_next    = r_done;

    unique case (r_state)
      IDLE: begin
        w_clk_cnt_next = '0;
        w_bit_idx_next = '0;
        w_serial_next  = 1'b1;
        w_active_next  = 1'b0;
        w_done_next    = 1'b0;
        if (i_Tx_DV) begin
          w_byte_next   = i_Tx_Byte;
          w_active_next = 1'b1;
          w_serial_next = 1'b0;
          w_state_next  = START;
        end
      end

      START: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          w_serial_next  = r_byte[0];
          w_state_next   = DATA;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end

      DATA: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          if (r_bit_idx != 3'd7) begin
            w_bit_idx_next = w_bit_idx_inc;
            w_serial_next  = r_byte[w_bit_idx_inc];
          end else begin
            w_bit_idx_next = '0;
            w_serial_next  = 1'b1;
            w_state_next   = STOP;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end

      STOP: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          w_done_next    = 1'b1;
          w_active_next  = 1'b0;
          w_state_next   = CLEANUP;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end

      CLEANUP: begin
        w_done_next  = 1'b0;
        w_state_next = IDLE;
      end

      default: begin
        w_state_next   = IDLE;
        w_clk_cnt_next = '0;
        w_bit_idx_next = '0;
        w_serial_next  = 1'b1;
        w_active_next  = 1'b0;
        w_done_next    = 1'b0;
      end
    endcase
  end

  assign o_Tx_Serial = r_serial;
  assign o_Tx_Active = r_active;
  assign o_Tx_Done   = r_done;

endmodule

// File: tb/tb_transmisor_uart.sv
`timescale 1ns/1ps
module tb_transmisor_uart;

  // 10 MHz clock, gated so reset can be checked with no clock running
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  always begin
    #50;
    if (clk_en) clk = ~clk;
  end

  logic       rst = 1'b0;
  logic       dv4 = 1'b0;
  logic [7:0] byte4 = '0;
  logic       ser4, act4, done4;
  logic       dv87 = 1'b0;
  logic [7:0] byte87 = '0;
  logic       ser87, act87, done87;

  transmisor_uart #(.CLKS_PER_BIT(4)) dut4 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv4), .i_Tx_Byte(byte4),
    .o_Tx_Serial(ser4), .o_Tx_Active(act4), .o_Tx_Done(done4)
  );

  transmisor_uart dut87 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv87), .i_Tx_Byte(byte87),
    .o_Tx_Serial(ser87), .o_Tx_Active(act87), .o_Tx_Done(done87)
  );

  // Monitor watches one DUT at a time
  logic sel87 = 1'b0;
  logic ser_m, act_m, done_m;
  assign ser_m  = sel87 ? ser87  : ser4;
  assign act_m  = sel87 ? act87  : act4;
  assign done_m = sel87 ? done87 : done4;

  int checks = 0;
  int passed = 0;
  int frames_seen = 0;
  int done_cnt = 0;
  int last_gap = 0;
  longint last_start = 0;
  logic [9:0] exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Reference frame: start 0, data LSB-first, stop 1 (bit 0 is sent first)
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [9:0] bits;
    int bit_err, act_err, done_err, cpb;
    bit aborted;
    longint ts;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done_m) chk("idle_done", done_m, 1'b0);
        if (ser_m === 1'b0) begin
          cpb = sel87 ? 87 : 4;
          bits = '0; bit_err = 0; act_err = 0; done_err = 0; aborted = 0;
          ts = $time;
          for (int i = 0; i < 10 * cpb; i++) begin
            if (i != 0) @(negedge clk);
            if (rst) begin
              aborted = 1;
              break;
            end
            if (i % cpb == 0) bits[i / cpb] = ser_m;
            else if (ser_m !== bits[i / cpb]) bit_err++;
            if (act_m !== 1'b1) act_err++;
            if (done_m !== 1'b0) done_err++;
          end
          if (!aborted) begin
            chk("bit_hold", bit_err, 0);
            chk("active_in_frame", act_err, 0);
            chk("done_in_frame", done_err, 0);
            @(negedge clk);
            chk("cleanup_done", done_m, 1'b1);
            chk("cleanup_active", act_m, 1'b0);
            chk("cleanup_line", ser_m, 1'b1);
            if (done_m) done_cnt++;
            @(negedge clk);
            chk("done_clear", done_m, 1'b0);
            chk("idle_line", ser_m, 1'b1);
            if (exp_q.size() == 0) chk("frame_expected", 0, 1);
            else chk("frame_bits", bits, exp_q.pop_front());
            if (frames_seen > 0) last_gap = int'((ts - last_start) / 100);
            last_start = ts;
            frames_seen++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send4(input logic [7:0] b);
    exp_q.push_back(frame_of(b));
    @(negedge clk);
    dv4 = 1'b1; byte4 = b;
    @(negedge clk);
    dv4 = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int k = 0; k < budget && frames_seen < n; k++) @(negedge clk);
    chk("frame_timeout", frames_seen >= n, 1);
  endtask

  initial begin : stim
    int f0, d0, low;
    logic [7:0] rb;

    // 1: reset with no clock
    #30 rst = 1'b1;
    #1;
    chk("rst_line", ser4, 1'b1);
    chk("rst_active", act4, 1'b0);
    chk("rst_done", done4, 1'b0);
    chk("rst_line87", ser87, 1'b1);
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    low = 0;
    repeat (100) begin
      @(negedge clk);
      if (ser4 !== 1'b1 || act4 !== 1'b0) low++;
    end
    chk("idle_100", low, 0);

    // 2: single frame 0xA5
    send4(8'hA5);
    wait_frames(1, 100);
    chk("done_once_A5", done_cnt, 1);

    // 3: back-to-back, DV held high, 0x00 then 0xFF
    exp_q.push_back(frame_of(8'h00));
    exp_q.push_back(frame_of(8'hFF));
    @(negedge clk);
    dv4 = 1'b1; byte4 = 8'h00;
    for (int k = 0; k < 10 && !act4; k++) @(negedge clk);
    chk("b2b_first_active", act4, 1'b1);
    byte4 = 8'hFF;
    for (int k = 0; k < 60 && !done4; k++) @(negedge clk);
    chk("b2b_first_done", done4, 1'b1);
    for (int k = 0; k < 10 && !act4; k++) @(negedge clk);
    chk("b2b_second_active", act4, 1'b1);
    dv4 = 1'b0;
    wait_frames(3, 100);
    chk("b2b_gap", last_gap, 42);

    // 4: busy strobe dropped, byte change ignored
    f0 = frames_seen; d0 = done_cnt;
    send4(8'h3C);
    repeat (15) @(negedge clk);
    dv4 = 1'b1; byte4 = 8'h99;
    @(negedge clk);
    dv4 = 1'b0;
    wait_frames(f0 + 1, 100);
    repeat (60) @(negedge clk);
    chk("drop_frames", frames_seen - f0, 1);
    chk("drop_done", done_cnt - d0, 1);

    // 5: reset mid-frame, then a clean frame
    f0 = frames_seen; d0 = done_cnt;
    @(negedge clk);
    dv4 = 1'b1; byte4 = 8'h55;
    @(negedge clk);
    dv4 = 1'b0;
    repeat (18) @(negedge clk);
    #10 rst = 1'b1;
    #1;
    chk("midrst_line", ser4, 1'b1);
    chk("midrst_active", act4, 1'b0);
    chk("midrst_done", done4, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    send4(8'h81);
    wait_frames(f0 + 1, 100);

    // 7: random bytes with random strobes while busy
    for (int n = 0; n < 6; n++) begin
      f0 = frames_seen;
      rb = 8'($urandom);
      send4(rb);
      repeat ($urandom_range(0, 30)) begin
        @(negedge clk);
        if (act4) begin
          dv4 = 1'($urandom);
          byte4 = 8'($urandom);
        end else dv4 = 1'b0;
      end
      @(negedge clk);
      dv4 = 1'b0;
      wait_frames(f0 + 1, 100);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // 6: default parameter, 0x7E
    repeat (10) @(negedge clk);
    sel87 = 1'b1;
    f0 = frames_seen;
    exp_q.push_back(frame_of(8'h7E));
    @(negedge clk);
    dv87 = 1'b1; byte87 = 8'h7E;
    @(negedge clk);
    dv87 = 1'b0;
    wait_frames(f0 + 1, 1200);

    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
